// File: rtl/hazard_scoreboard_pkg.sv
// ============================================================================
// Module : hazard_scoreboard_pkg
// Brief  : Shared encodings and default latencies for the hazard scoreboard.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package hazard_scoreboard_pkg;

    // Forward-source select encoding; E/M/W match the entry stage numbering.
    localparam logic [1:0] FWD_RF = 2'd0;
    localparam logic [1:0] FWD_E  = 2'd1;
    localparam logic [1:0] FWD_M  = 2'd2;
    localparam logic [1:0] FWD_W  = 2'd3;

    localparam logic [1:0] TUSE_NONE = 2'b11;

    localparam int DEF_MUL_LAT = 5;
    localparam int DEF_DIV_LAT = 10;

endpackage

`default_nettype wire

// File: rtl/hazard_scoreboard_sb_entry.sv
// ============================================================================
// Module : sb_entry
// Brief  : One register's pending-write record (valid, remaining Tnew, stage).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sb_entry #(
    parameter int TW     = 2,
    parameter int NSTAGE = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [TW-1:0] loadTnew,
    output logic          valid,
    output logic [TW-1:0] tnew,
    output logic [1:0]    stage
);

    localparam logic [1:0] c_lastStage = 2'(NSTAGE);

    always_ff @(posedge clk) begin
        if (!reset) begin
            valid <= 1'b0;
            tnew  <= '0;
            stage <= '0;
        end else if (load) begin
            // A new writer replaces any older in-flight write to this register.
            valid <= 1'b1;
            tnew  <= loadTnew;
            stage <= 2'd1;
        end else if (valid) begin
            tnew  <= (tnew != '0) ? tnew - TW'(1) : tnew;
            stage <= stage + 2'd1;
            if (stage == c_lastStage) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/hazard_scoreboard.sv
// ============================================================================
// Module : hazard_scoreboard
// Brief  : Per-register Tuse/Tnew scoreboard driving D-stage stall and forwarding.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int NREG    = 32,
    parameter int AW      = 5,
    parameter int TW      = 2,
    parameter int NSTAGE  = 3,
    parameter int MUL_LAT = DEF_MUL_LAT,
    parameter int DIV_LAT = DEF_DIV_LAT,
    parameter int CW      = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          d_valid,
    input  logic [AW-1:0] rs_addr,
    input  logic [AW-1:0] rt_addr,
    input  logic [TW-1:0] rs_tuse,
    input  logic [TW-1:0] rt_tuse,
    input  logic          dst_we,
    input  logic [AW-1:0] dst_addr,
    input  logic [TW-1:0] dst_tnew,
    input  logic          md_start,
    input  logic          md_is_div,
    input  logic          md_use,
    output logic          stall,
    output logic [1:0]    fwd_rs,
    output logic [1:0]    fwd_rt,
    output logic          md_busy
);

    localparam logic [TW-1:0] c_tuseNone = {TW{1'b1}};

    logic [NREG-1:0] w_valid;
    logic [TW-1:0]   w_tnew  [NREG];
    logic [1:0]      w_stage [NREG];
    logic            w_issue;
    logic            w_rsHit, w_rtHit, w_rsStall, w_rtStall;
    logic [CW-1:0]   r_mdCnt;

    // Register 0 is never tracked, so its slot reads as permanently empty.
    assign w_valid[0] = 1'b0;
    assign w_tnew[0]  = '0;
    assign w_stage[0] = FWD_RF;

    for (genvar i = 1; i < NREG; i++) begin : g_entry
        sb_entry #(
            .TW     (TW),
            .NSTAGE (NSTAGE)
        ) u_entry (
            .clk      (clk),
            .reset    (reset),
            .load     (w_issue && dst_we && (dst_addr == AW'(i))),
            .loadTnew (dst_tnew),
            .valid    (w_valid[i]),
            .tnew     (w_tnew[i]),
            .stage    (w_stage[i])
        );
    end

    // Lookups see pre-update state, so an instruction never matches its own write.
    assign w_rsHit   = w_valid[rs_addr] && (rs_addr != '0) && (rs_tuse != c_tuseNone);
    assign w_rtHit   = w_valid[rt_addr] && (rt_addr != '0) && (rt_tuse != c_tuseNone);
    assign w_rsStall = w_rsHit && (rs_tuse < w_tnew[rs_addr]);
    assign w_rtStall = w_rtHit && (rt_tuse < w_tnew[rt_addr]);

    assign fwd_rs = (w_rsHit && !w_rsStall) ? w_stage[rs_addr] : FWD_RF;
    assign fwd_rt = (w_rtHit && !w_rtStall) ? w_stage[rt_addr] : FWD_RF;

    assign md_busy = (r_mdCnt != '0);
    assign stall   = d_valid && (w_rsStall || w_rtStall || (md_use && md_busy));
    assign w_issue = d_valid && !stall;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_mdCnt <= '0;
        end else if (w_issue && md_start) begin
            r_mdCnt <= md_is_div ? CW'(DIV_LAT) : CW'(MUL_LAT);
        end else if (r_mdCnt != '0) begin
            r_mdCnt <= r_mdCnt - CW'(1);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
// ============================================================================
// Module : tb_hazard_scoreboard
// Brief  : Directed vector bench for hazard_scoreboard.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_scoreboard;

    typedef struct {
        bit       rstn;
        bit       dv;
        bit [4:0] rs;
        bit [1:0] rsTu;
        bit [4:0] rt;
        bit [1:0] rtTu;
        bit       we;
        bit [4:0] dst;
        bit [1:0] tn;
        bit       ms;
        bit       mdiv;
        bit       mu;
        bit       chk;
        bit       eStall;
        bit [1:0] eFwdRs;
        bit [1:0] eFwdRt;
        bit       eBusy;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       d_valid;
    logic [4:0] rs_addr, rt_addr, dst_addr;
    logic [1:0] rs_tuse, rt_tuse, dst_tnew;
    logic       dst_we, md_start, md_is_div, md_use;
    logic       stall, md_busy;
    logic [1:0] fwd_rs, fwd_rt;

    int nCmp = 0;
    int nBad = 0;

    always #5 clk = ~clk;

    hazard_scoreboard dut (
        .clk       (clk),
        .reset     (reset),
        .d_valid   (d_valid),
        .rs_addr   (rs_addr),
        .rt_addr   (rt_addr),
        .rs_tuse   (rs_tuse),
        .rt_tuse   (rt_tuse),
        .dst_we    (dst_we),
        .dst_addr  (dst_addr),
        .dst_tnew  (dst_tnew),
        .md_start  (md_start),
        .md_is_div (md_is_div),
        .md_use    (md_use),
        .stall     (stall),
        .fwd_rs    (fwd_rs),
        .fwd_rt    (fwd_rt),
        .md_busy   (md_busy)
    );

    function automatic vec_t mk(bit rstn, bit dv, bit [4:0] rs, bit [1:0] rsTu,
                                bit [4:0] rt, bit [1:0] rtTu, bit we, bit [4:0] dst,
                                bit [1:0] tn, bit ms, bit mdiv, bit mu, bit chk,
                                bit eStall, bit [1:0] eFwdRs, bit [1:0] eFwdRt, bit eBusy);
        vec_t v;
        v.rstn = rstn; v.dv = dv; v.rs = rs; v.rsTu = rsTu; v.rt = rt; v.rtTu = rtTu;
        v.we = we; v.dst = dst; v.tn = tn; v.ms = ms; v.mdiv = mdiv; v.mu = mu;
        v.chk = chk; v.eStall = eStall; v.eFwdRs = eFwdRs; v.eFwdRt = eFwdRt; v.eBusy = eBusy;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        reset = v.rstn; d_valid = v.dv; rs_addr = v.rs; rs_tuse = v.rsTu;
        rt_addr = v.rt; rt_tuse = v.rtTu; dst_we = v.we; dst_addr = v.dst;
        dst_tnew = v.tn; md_start = v.ms; md_is_div = v.mdiv; md_use = v.mu;
    endtask

    task automatic check(input string name, input int act, input int exp);
        nCmp++;
        if (act != exp) begin
            nBad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkAll(input string tag, input vec_t v);
        check({tag, ".stall"}, int'(stall), int'(v.eStall));
        check({tag, ".fwd_rs"}, int'(fwd_rs), int'(v.eFwdRs));
        check({tag, ".fwd_rt"}, int'(fwd_rt), int'(v.eFwdRt));
        check({tag, ".md_busy"}, int'(md_busy), int'(v.eBusy));
    endtask

    // Drive one D-stage cycle, sample mid-cycle, advance past the next edge.
    task automatic step(input string tag, input vec_t v);
        drive(v);
        @(negedge clk);
        if (v.chk) checkAll(tag, v);
        @(posedge clk);
        #1;
    endtask

    localparam vec_t NOP = '{rstn: 1'b1, dv: 1'b1, rs: 5'd0, rsTu: 2'd3, rt: 5'd0, rtTu: 2'd3,
                            we: 1'b0, dst: 5'd0, tn: 2'd0, ms: 1'b0, mdiv: 1'b0, mu: 1'b0,
                            chk: 1'b0, eStall: 1'b0, eFwdRs: 2'd0, eFwdRt: 2'd0, eBusy: 1'b0};

    vec_t tbl[$];

    initial begin
        vec_t v;
        int cnt;
        bit busyTracks;

        //        rstn dv rs  rsTu rt  rtTu we dst tn ms dv mu chk st fRs fRt bsy
        tbl.push_back(mk(0, 0, 0, 3, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // load-use
        tbl.push_back(mk(1, 1, 0, 3, 0, 3, 1, 3, 2, 0, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 3, 1, 0, 3, 1, 4, 1, 0, 0, 0, 1, 1, 0, 0, 0));
        tbl.push_back(mk(1, 1, 3, 1, 0, 3, 1, 4, 1, 0, 0, 0, 1, 0, 2, 0, 0));
        // ALU back-to-back, branch reader then store-data reader
        tbl.push_back(mk(1, 1, 0, 3, 0, 3, 1, 5, 1, 0, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 5, 0, 0, 3, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0));
        tbl.push_back(mk(1, 1, 5, 0, 0, 3, 0, 0, 0, 0, 0, 0, 1, 0, 2, 0, 0));
        tbl.push_back(mk(1, 1, 0, 3, 0, 3, 1, 5, 1, 0, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 3, 5, 2, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0));
        // overwrite: younger writer of $7 wins
        tbl.push_back(mk(1, 1, 0, 3, 0, 3, 1, 7, 2, 0, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 3, 0, 3, 1, 7, 1, 0, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 7, 1, 7, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0));
        // register 0 and unused operand
        tbl.push_back(mk(1, 1, 0, 3, 0, 3, 1, 0, 2, 0, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 3, 0, 3, 1, 9, 2, 0, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 9, 2, 9, 3, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0));
        // d_valid=0 forces no stall and creates no entry
        tbl.push_back(mk(1, 1, 0, 3, 0, 3, 1,10, 2, 0, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0,10, 0, 0, 3, 1,11, 2, 0, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1,11, 0, 0, 3, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        // W-stage forward then retire
        tbl.push_back(mk(1, 1, 0, 3, 0, 3, 1,12, 1, 0, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(NOP);
        tbl.push_back(NOP);
        tbl.push_back(mk(1, 1,12, 0, 0, 3, 0, 0, 0, 0, 0, 0, 1, 0, 3, 0, 0));
        tbl.push_back(mk(1, 1,12, 0, 0, 3, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        // retire of $13 in the same cycle as a new write of $13
        tbl.push_back(mk(1, 1, 0, 3, 0, 3, 1,13, 1, 0, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(NOP);
        tbl.push_back(NOP);
        tbl.push_back(mk(1, 1,13, 0, 0, 3, 1,13, 2, 0, 0, 0, 1, 0, 3, 0, 0));
        tbl.push_back(mk(1, 1,13, 0, 0, 3, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0));
        tbl.push_back(mk(1, 1,13, 0, 0, 3, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0));
        tbl.push_back(mk(1, 1,13, 0, 0, 3, 0, 0, 0, 0, 0, 0, 1, 0, 3, 0, 0));

        drive(NOP);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < tbl.size(); i++) begin
            step($sformatf("vec%0d", i), tbl[i]);
        end

        // md latency: issue div/mult, then mfhi stalls for the full latency
        for (int k = 0; k < 2; k++) begin
            v = NOP; v.ms = 1'b1; v.mu = 1'b1; v.mdiv = (k == 0); v.chk = 1'b1;
            step(k == 0 ? "divIssue" : "multIssue", v);
            v = NOP; v.mu = 1'b1;
            drive(v);
            cnt = 0;
            busyTracks = 1'b1;
            @(negedge clk);
            while (stall && cnt < 50) begin
                if (md_busy !== 1'b1) busyTracks = 1'b0;
                cnt++;
                @(negedge clk);
            end
            check(k == 0 ? "divStallCycles" : "multStallCycles", cnt, k == 0 ? 10 : 5);
            check(k == 0 ? "divBusyDuringStall" : "multBusyDuringStall", int'(busyTracks), 1);
            check(k == 0 ? "divBusyAfter" : "multBusyAfter", int'(md_busy), 0);
            @(posedge clk);
            #1;
        end

        // reset mid-flight with md_cnt=7 and a pending $3 entry
        v = NOP; v.ms = 1'b1; v.mu = 1'b1; v.mdiv = 1'b1;
        step("rstDiv", v);
        step("rstNop1", NOP);
        step("rstNop2", NOP);
        v = NOP; v.we = 1'b1; v.dst = 5'd3; v.tn = 2'd2;
        step("rstWr3", v);
        v = NOP; v.rstn = 1'b0; v.dv = 1'b0;
        drive(v);
        @(negedge clk);
        check("preResetBusy", int'(md_busy), 1);
        @(posedge clk);
        #1;
        v = NOP; v.rs = 5'd3; v.rsTu = 2'd0; v.rt = 5'd3; v.rtTu = 2'd0; v.mu = 1'b1; v.chk = 1'b1;
        step("postReset", v);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule

`default_nettype wire
